// File: rtl/led_status_ctrl.sv
// Per-channel status LED driver: OFF/ON/SLOW/FAST/CODE/EXT modes with run-time configuration.
// Optional mode 6 BREATHE (triangle-ramp PWM) is built only when LED_STATUS_BREATHE_EN is defined.
module led_status_ctrl #(
    parameter int LED_NUM   = 6,
    parameter int CLK_DIV   = 5_000_000,
    parameter int CODE_W    = 4,
    parameter int BURST_GAP = 4,
    localparam int CHAN_W   = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic               clk_50m,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CHAN_W-1:0]  cfg_chan,
    input  logic [2:0]         cfg_mode,
    input  logic [CODE_W-1:0]  cfg_code,
    output logic               cfg_err,
    input  logic [LED_NUM-1:0] led_ext,
    output logic               tick,
    output logic [LED_NUM-1:0] led
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int Q     = CLK_DIV / 4;
    localparam int GAP_W = (BURST_GAP > 1) ? $clog2(BURST_GAP) : 1;

    localparam logic [2:0] M_OFF     = 3'd0;
    localparam logic [2:0] M_ON      = 3'd1;
    localparam logic [2:0] M_SLOW    = 3'd2;
    localparam logic [2:0] M_FAST    = 3'd3;
    localparam logic [2:0] M_CODE    = 3'd4;
    localparam logic [2:0] M_EXT     = 3'd5;
    localparam logic [2:0] M_BREATHE = 3'd6;

    typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH, GAP} code_state_t;

    logic [CNT_W-1:0] cnt;
    logic             slow_ph, fast_ph;
    logic             slow_nx, fast_nx, fast_strobe;

    logic accept, chan_ok, mode_ok, write_ok;

    logic [2:0]        mode     [LED_NUM];
    logic [2:0]        mode_nx  [LED_NUM];
    logic [CODE_W-1:0] code     [LED_NUM];
    logic [CODE_W-1:0] code_nx  [LED_NUM];
    logic [CODE_W-1:0] flash    [LED_NUM];
    logic [CODE_W-1:0] flash_nx [LED_NUM];
    logic [GAP_W-1:0]  gap      [LED_NUM];
    logic [GAP_W-1:0]  gap_nx   [LED_NUM];
    code_state_t       state    [LED_NUM];
    code_state_t       state_nx [LED_NUM];
    logic [LED_NUM-1:0] led_nx;

    always_comb begin
        tick        = (int'(cnt) == CLK_DIV - 1);
        fast_strobe = (int'(cnt) == Q - 1)     || (int'(cnt) == 2 * Q - 1) ||
                      (int'(cnt) == 3 * Q - 1) || (int'(cnt) == 4 * Q - 1);
        slow_nx     = slow_ph ^ tick;
        fast_nx     = fast_ph ^ fast_strobe;
    end

    // Prescaler and global phases are shared by every channel and never touched by writes
    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            slow_ph <= 1'b0;
            fast_ph <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + CNT_W'(1);
            slow_ph <= slow_nx;
            fast_ph <= fast_nx;
        end
    end

    always_comb begin
        accept  = cfg_valid && cfg_ready;
        chan_ok = (int'(cfg_chan) < LED_NUM);
`ifdef LED_STATUS_BREATHE_EN
        mode_ok = (cfg_mode != 3'd7);
`else
        mode_ok = (cfg_mode < M_BREATHE);
`endif
        write_ok = accept && chan_ok && mode_ok;
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= !accept;
            cfg_err   <= accept && !(chan_ok && mode_ok);
        end
    end

`ifdef LED_STATUS_BREATHE_EN
    localparam int STEP   = (CLK_DIV / 256 > 0) ? CLK_DIV / 256 : 1;
    localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;

    logic [7:0]        pwm, duty;
    logic              duty_up;
    logic [STEP_W-1:0] step_cnt;
    logic              breathe_led;

    assign breathe_led = (pwm < duty);

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            pwm      <= '0;
            duty     <= '0;
            duty_up  <= 1'b1;
            step_cnt <= '0;
        end else begin
            pwm <= pwm + 8'd1;
            if (int'(step_cnt) == STEP - 1) begin
                step_cnt <= '0;
                if (duty_up) begin
                    if (duty == 8'hFF) begin
                        duty_up <= 1'b0;
                        duty    <= 8'hFE;
                    end else begin
                        duty <= duty + 8'd1;
                    end
                end else begin
                    if (duty == 8'h00) begin
                        duty_up <= 1'b1;
                        duty    <= 8'h01;
                    end else begin
                        duty <= duty - 8'd1;
                    end
                end
            end else begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
        end
    end
`endif

    // A write to a channel overrides a coincident tick for that channel only
    always_comb begin
        led_nx = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            mode_nx[i]  = mode[i];
            code_nx[i]  = code[i];
            state_nx[i] = state[i];
            flash_nx[i] = flash[i];
            gap_nx[i]   = gap[i];
            if (write_ok && (int'(cfg_chan) == i)) begin
                mode_nx[i]  = cfg_mode;
                code_nx[i]  = cfg_code;
                state_nx[i] = IDLE;
                flash_nx[i] = '0;
                gap_nx[i]   = '0;
            end else if (tick && (mode[i] == M_CODE)) begin
                case (state[i])
                    IDLE: begin
                        if (code[i] != '0) state_nx[i] = ON_PH;
                    end
                    ON_PH: begin
                        state_nx[i] = OFF_PH;
                        flash_nx[i] = flash[i] + CODE_W'(1);
                    end
                    OFF_PH: begin
                        if (flash[i] < code[i]) begin
                            state_nx[i] = ON_PH;
                        end else begin
                            state_nx[i] = GAP;
                            gap_nx[i]   = '0;
                        end
                    end
                    default: begin
                        if (gap[i] == GAP_W'(BURST_GAP - 1)) begin
                            state_nx[i] = ON_PH;
                            flash_nx[i] = '0;
                            gap_nx[i]   = '0;
                        end else begin
                            gap_nx[i] = gap[i] + GAP_W'(1);
                        end
                    end
                endcase
            end

            // led is computed from next-state values so a write shows after one cycle
            case (mode_nx[i])
                M_OFF:   led_nx[i] = 1'b0;
                M_ON:    led_nx[i] = 1'b1;
                M_SLOW:  led_nx[i] = slow_nx;
                M_FAST:  led_nx[i] = fast_nx;
                M_CODE:  led_nx[i] = (state_nx[i] == ON_PH);
                M_EXT:   led_nx[i] = led_ext[i];
`ifdef LED_STATUS_BREATHE_EN
                M_BREATHE: led_nx[i] = breathe_led;
`endif
                default: led_nx[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LED_NUM; i++) begin
                mode[i]  <= M_OFF;
                code[i]  <= '0;
                state[i] <= IDLE;
                flash[i] <= '0;
                gap[i]   <= '0;
            end
            led <= '0;
        end else begin
            for (int i = 0; i < LED_NUM; i++) begin
                mode[i]  <= mode_nx[i];
                code[i]  <= code_nx[i];
                state[i] <= state_nx[i];
                flash[i] <= flash_nx[i];
                gap[i]   <= gap_nx[i];
            end
            led <= led_nx;
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl: a cycle-count based reference model pushes expected
// outputs every clock, a monitor pops and compares them on the falling edge.
module tb_led_status_ctrl;

    localparam int LED_NUM   = 6;
    localparam int CLK_DIV   = 8;
    localparam int CODE_W    = 4;
    localparam int BURST_GAP = 4;
    localparam int Q         = CLK_DIV / 4;
`ifdef LED_STATUS_BREATHE_EN
    localparam bit BREATHE = 1'b1;
`else
    localparam bit BREATHE = 1'b0;
`endif

    logic               clk_50m = 1'b0;
    logic               reset_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [2:0]         cfg_chan = '0;
    logic [2:0]         cfg_mode = '0;
    logic [CODE_W-1:0]  cfg_code = '0;
    logic               cfg_err;
    logic [LED_NUM-1:0] led_ext = '0;
    logic               tick;
    logic [LED_NUM-1:0] led;

    led_status_ctrl #(
        .LED_NUM(LED_NUM), .CLK_DIV(CLK_DIV), .CODE_W(CODE_W), .BURST_GAP(BURST_GAP)
    ) dut (
        .clk_50m(clk_50m), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_code(cfg_code), .cfg_err(cfg_err),
        .led_ext(led_ext), .tick(tick), .led(led)
    );

    always #5 clk_50m = ~clk_50m;

    typedef struct packed {
        logic [LED_NUM-1:0] led;
        logic               ready;
        logic               err;
        logic               tick;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycles since reset, ticks since each channel's last write
    longint n;
    int     m_mode  [LED_NUM];
    int     m_code  [LED_NUM];
    int     m_ticks [LED_NUM];
    bit     m_ready;
    bit     ext_pat = 1'b0;

    function automatic bit model_led(input int i, input logic ext);
        int period, q;
        case (m_mode[i])
            1: return 1'b1;
            2: return bit'((n / CLK_DIV) % 2);
            3: return bit'((n / Q) % 2);
            4: begin
                if (m_code[i] == 0 || m_ticks[i] == 0) return 1'b0;
                period = 2 * m_code[i] + BURST_GAP;
                q = (m_ticks[i] - 1) % period;
                return (q < 2 * m_code[i]) && (q % 2 == 0);
            end
            5: return ext;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        exp_t e;
        bit acc, ok, tk;
        if (!reset_n) begin
            for (int i = 0; i < LED_NUM; i++) begin
                m_mode[i] = 0; m_code[i] = 0; m_ticks[i] = 0;
            end
            n = 0;
            m_ready = 1'b1;
            e = '{led: '0, ready: 1'b1, err: 1'b0, tick: 1'b0};
        end else begin
            acc = cfg_valid && m_ready;
            ok  = (int'(cfg_chan) < LED_NUM) && (cfg_mode != 3'd7) && (BREATHE || cfg_mode != 3'd6);
            tk  = (n % CLK_DIV == CLK_DIV - 1);
            if (tk) for (int i = 0; i < LED_NUM; i++) m_ticks[i]++;
            if (acc && ok) begin
                m_mode[cfg_chan]  = int'(cfg_mode);
                m_code[cfg_chan]  = int'(cfg_code);
                m_ticks[cfg_chan] = 0;
            end
            n++;
            m_ready = !acc;
            e.ready = m_ready;
            e.err   = acc && !ok;
            e.tick  = (n % CLK_DIV == CLK_DIV - 1);
            for (int i = 0; i < LED_NUM; i++) e.led[i] = model_led(i, led_ext[i]);
        end
        sb.push_back(e);
    endtask

    always @(posedge clk_50m) model_step();

    task automatic check_vec(input string name, input logic [LED_NUM-1:0] act, input logic [LED_NUM-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_vec("led", led, e.led);
        check_bit("cfg_ready", cfg_ready, e.ready);
        check_bit("cfg_err", cfg_err, e.err);
        check_bit("tick", tick, e.tick);
    endtask

    always @(negedge clk_50m) monitor_step();

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_50m);
            ext_pat = ~ext_pat;
            led_ext = {ext_pat, 5'($urandom)};
        end
    endtask

    task automatic drive(input int ch, input int md, input int cd);
        cfg_valid = 1'b1;
        cfg_chan  = 3'(ch);
        cfg_mode  = 3'(md);
        cfg_code  = CODE_W'(cd);
        @(negedge clk_50m);
        cfg_valid = 1'b0;
    endtask

    task automatic write(input int ch, input int md, input int cd);
        int tries = 0;
        @(negedge clk_50m);
        while (!cfg_ready && tries < 4) begin
            @(negedge clk_50m);
            tries++;
        end
        if (!cfg_ready) begin
            check_bit("write_ready_timeout", cfg_ready, 1'b1);
            return;
        end
        drive(ch, md, cd);
    endtask

    task automatic write_on_tick(input int ch, input int md, input int cd);
        int tries = 0;
        @(negedge clk_50m);
        while (!(tick && cfg_ready) && tries < 20) begin
            @(negedge clk_50m);
            tries++;
        end
        if (!(tick && cfg_ready)) begin
            check_bit("tick_wait_timeout", tick, 1'b1);
            return;
        end
        drive(ch, md, cd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_cnt, err_cnt, md;

        // Reset and free-running prescaler
        idle(3);
        reset_n = 1'b1;
        idle(24);

        // ON then SLOW in lockstep with another SLOW channel
        write(2, 1, 0);
        idle(3);
        write(2, 2, 0);
        write(1, 2, 0);
        write(3, 3, 0);
        idle(40);

        // Blink code 3, then restart during the second flash
        write(0, 4, 3);
        idle(120);
        write(0, 4, 3);
        idle(28);
        write(0, 4, 3);
        idle(130);
        write(4, 4, 0);
        idle(30);

        // Held cfg_valid with bad writes: one accept every other cycle
        acc_cnt = 0;
        err_cnt = 0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            case (acc_cnt)
                0:       begin cfg_chan = 3'd6; cfg_mode = 3'd1; end
                1:       begin cfg_chan = 3'd2; cfg_mode = 3'd7; end
                default: begin cfg_chan = 3'd1; cfg_mode = BREATHE ? 3'd7 : 3'd6; end
            endcase
            if (cfg_ready) acc_cnt++;
            err_cnt += int'(cfg_err);
            @(negedge clk_50m);
        end
        cfg_valid = 1'b0;
        err_cnt += int'(cfg_err);
        @(negedge clk_50m);
        err_cnt += int'(cfg_err);
        check_int("held_valid_accepts", acc_cnt, 3);
        check_int("bad_write_err_pulses", err_cnt, 3);
        idle(10);

        // External pass-through, and writes landing on the tick cycle
        write(5, 5, 0);
        idle(20);
        write_on_tick(3, 3, 0);
        idle(20);
        write_on_tick(4, 4, 2);
        idle(60);

        // Randomized configuration traffic
        for (int it = 0; it < 150; it++) begin
            idle($urandom_range(0, 15));
            md = $urandom_range(0, 7);
            if (BREATHE && md == 6) md = 7;
            write($urandom_range(0, 7), md, $urandom_range(0, 5));
        end
        idle(40);

        // Asynchronous reset in the middle of a code burst
        write(0, 4, 3);
        idle(20);
        @(negedge clk_50m);
        #2 reset_n = 1'b0;
        #1;
        check_vec("async_reset_led", led, '0);
        check_bit("async_reset_ready", cfg_ready, 1'b1);
        check_bit("async_reset_tick", tick, 1'b0);
        idle(2);
        reset_n = 1'b1;
        idle(40);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
